// File: rtl/conv_encoder_if.sv
// rtl/conv_encoder_if.sv - AXI-Stream style word channel used on both sides of the convolutional encoder
interface conv_encoder_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] tdata;
    logic [3:0]       tuser;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (output tdata, output tuser, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tuser, input tvalid, input tlast, output tready);
endinterface

// File: rtl/conv_encoder.sv
// rtl/conv_encoder.sv - rate-1/2 K=7 convolutional encoder (133o/171o), two output beats per input word
// Optional packet counter on m_axis enabled by defining CONV_ENC_STATS_EN.
module conv_encoder #(
    parameter int WIDTH = 32
) (
    input  logic                aclk,
    input  logic                aresetn,
    conv_encoder_if.slave       s_axis,
    conv_encoder_if.master      m_axis
`ifdef CONV_ENC_STATS_EN
    ,
    output logic [15:0]         pkt_count
`endif
);

    typedef enum logic [1:0] {EMPTY, BEAT0, BEAT1} state_t;

    state_t             state;
    logic [5:0]         hist_q;
    logic [WIDTH-1:0]   upper_q;
    logic               last_q;
    logic [WIDTH-1:0]   tdata_q;
    logic [3:0]         tuser_q;
    logic               tvalid_q;
    logic               tlast_q;

    logic               s_ready;
    logic               s_hs;
    logic               m_hs;
    logic [WIDTH+5:0]   ext;
    logic [2*WIDTH-1:0] coded;

    assign s_ready = (state == EMPTY) | ((state == BEAT1) & m_axis.tready);
    assign s_hs    = s_axis.tvalid & s_ready;
    assign m_hs    = tvalid_q & m_axis.tready;

    // ext[i+6] is input bit i; ext[i+6-k] is the bit k steps earlier, reaching into the history.
    assign ext = {s_axis.tdata, hist_q};

    always_comb begin
        coded = '0;
        for (int i = 0; i < WIDTH; i++) begin
            coded[2*i]   = ext[i+6] ^ ext[i+4] ^ ext[i+3] ^ ext[i+1] ^ ext[i];
            coded[2*i+1] = ext[i+6] ^ ext[i+5] ^ ext[i+4] ^ ext[i+3] ^ ext[i];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= EMPTY;
            hist_q   <= '0;
            upper_q  <= '0;
            last_q   <= 1'b0;
            tdata_q  <= '0;
            tuser_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else if (s_hs) begin
            hist_q   <= s_axis.tlast ? 6'b0 : s_axis.tdata[WIDTH-1 -: 6];
            tdata_q  <= coded[WIDTH-1:0];
            upper_q  <= coded[2*WIDTH-1:WIDTH];
            tuser_q  <= s_axis.tuser;
            last_q   <= s_axis.tlast;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            state    <= BEAT0;
        end else begin
            case (state)
                BEAT0: begin
                    if (m_axis.tready) begin
                        tdata_q <= upper_q;
                        tlast_q <= last_q;
                        state   <= BEAT1;
                    end
                end
                BEAT1: begin
                    if (m_axis.tready) begin
                        tvalid_q <= 1'b0;
                        state    <= EMPTY;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CONV_ENC_STATS_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_count <= '0;
        end else if (m_hs && tlast_q) begin
            pkt_count <= pkt_count + 16'd1;
        end
    end
`endif

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tuser  = tuser_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;

endmodule

// File: tb/tb_conv_encoder.sv
// tb/tb_conv_encoder.sv - randomized self-checking bench for conv_encoder against a bit-queue reference model
module tb_conv_encoder;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] data;
        logic [3:0]   user;
        logic         last;
    } beat_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
`ifdef CONV_ENC_STATS_EN
    logic [15:0] pkt_count;
`endif

    conv_encoder_if #(.WIDTH(W)) s_if ();
    conv_encoder_if #(.WIDTH(W)) m_if ();

    conv_encoder #(.WIDTH(W)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .s_axis    (s_if),
        .m_axis    (m_if)
`ifdef CONV_ENC_STATS_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    always #5 aclk = ~aclk;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    acc_cyc = 0;
    bit    use_model = 1'b0;
    bit    rand_rdy = 1'b0;
    beat_t exp_q[$];
    bit    hist_q[$];
    bit    stall = 1'b0;
    beat_t held;
    beat_t e;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: the whole packet's bit history kept in a queue; bits before packet start are zero.
    function automatic bit tap(input int k);
        tap = (hist_q.size() > k) ? hist_q[hist_q.size()-1-k] : 1'b0;
    endfunction

    task automatic model_word(input logic [W-1:0] d, input logic [3:0] u, input logic l);
        logic [63:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            hist_q.push_back(d[i]);
            c[2*i]   = tap(0) ^ tap(2) ^ tap(3) ^ tap(5) ^ tap(6);
            c[2*i+1] = tap(0) ^ tap(1) ^ tap(2) ^ tap(3) ^ tap(6);
        end
        if (use_model) begin
            exp_q.push_back('{c[31:0], u, 1'b0});
            exp_q.push_back('{c[63:32], u, l});
        end
        if (l) hist_q.delete();
    endtask

    task automatic exp_push(input logic [W-1:0] d, input logic [3:0] u, input logic l);
        exp_q.push_back('{d, u, l});
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic [3:0] u, input logic l);
        bit ok;
        ok = 1'b0;
        s_if.tdata  = d;
        s_if.tuser  = u;
        s_if.tlast  = l;
        s_if.tvalid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge aclk);
            ok = s_if.tready;
            @(posedge aclk);
            #1;
        end
        if (!ok) check("accept_timeout", 64'(ok), 64'(1));
        else begin
            acc_cyc = cyc;
            model_word(d, u, l);
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge aclk);
        check("drain_left", 64'(exp_q.size()), 64'(0));
        @(posedge aclk);
        #1;
    endtask

    initial forever begin
        @(posedge aclk);
        cyc++;
        #1;
        if (rand_rdy) m_if.tready = ($urandom % 4) != 0;
    end

    // Output monitor: consumes beats on handshake and checks hold-under-backpressure.
    initial forever begin
        @(negedge aclk);
        if (!aresetn) stall = 1'b0;
        else begin
            if (stall) begin
                check("hold_valid", 64'(m_if.tvalid), 64'(1));
                check("hold_beat", 64'({m_if.tdata, m_if.tuser, m_if.tlast}), 64'(held));
            end
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) check("unexpected_beat", 64'(1), 64'(0));
                else begin
                    e = exp_q.pop_front();
                    check("tdata", 64'(m_if.tdata), 64'(e.data));
                    check("tuser", 64'(m_if.tuser), 64'(e.user));
                    check("tlast", 64'(m_if.tlast), 64'(e.last));
                end
                stall = 1'b0;
            end else if (m_if.tvalid) begin
                stall = 1'b1;
                held  = '{m_if.tdata, m_if.tuser, m_if.tlast};
            end else stall = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_cyc;
        int npkt;
        logic [3:0] u;
        s_if.tdata  = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid", 64'(m_if.tvalid), 64'(0));
        check("rst_tdata", 64'(m_if.tdata), 64'(0));
        check("rst_tuser", 64'(m_if.tuser), 64'(0));
        check("rst_tlast", 64'(m_if.tlast), 64'(0));
        check("rst_s_tready", 64'(s_if.tready), 64'(1));
`ifdef CONV_ENC_STATS_EN
        check("rst_pkt_count", 64'(pkt_count), 64'(0));
`endif
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Directed vectors with hand-derived constants.
        use_model = 1'b0;
        exp_push(32'h0, 4'h3, 1'b0); exp_push(32'h0, 4'h3, 1'b1);
        send_word(32'h0, 4'h3, 1'b1);
        drain();

        exp_push(32'h0000_34FB, 4'h1, 1'b0); exp_push(32'h0, 4'h1, 1'b0);
        exp_push(32'h0, 4'h2, 1'b0);         exp_push(32'h0, 4'h2, 1'b1);
        send_word(32'h1, 4'h1, 1'b0);
        send_word(32'h0, 4'h2, 1'b1);
        drain();

        exp_push(32'h0, 4'h4, 1'b0);         exp_push(32'hC000_0000, 4'h4, 1'b0);
        exp_push(32'h0000_0D3E, 4'h5, 1'b0); exp_push(32'h0, 4'h5, 1'b1);
        send_word(32'h8000_0000, 4'h4, 1'b0);
        send_word(32'h0, 4'h5, 1'b1);
        drain();

        exp_push(32'h0, 4'h6, 1'b0); exp_push(32'hC000_0000, 4'h6, 1'b1);
        exp_push(32'h0, 4'h7, 1'b0); exp_push(32'h0, 4'h7, 1'b1);
        send_word(32'h8000_0000, 4'h6, 1'b1);
        send_word(32'h0, 4'h7, 1'b1);
        drain();

        // Backpressure during BEAT0.
        use_model = 1'b1;
        m_if.tready = 1'b0;
        send_word(32'h1, 4'h9, 1'b1);
        repeat (5) begin
            @(negedge aclk);
            check("bp_tvalid", 64'(m_if.tvalid), 64'(1));
            check("bp_tdata", 64'(m_if.tdata), 64'(32'h0000_34FB));
            check("bp_s_tready", 64'(s_if.tready), 64'(0));
        end
        @(posedge aclk);
        #1;
        m_if.tready = 1'b1;
        drain();

        // Streaming throughput: one word every two cycles.
        for (int i = 0; i < 8; i++) begin
            send_word($urandom, 4'($urandom_range(0, 15)), i == 7);
            if (i == 0) first_cyc = acc_cyc;
        end
        check("throughput_cycles", 64'(acc_cyc - first_cyc), 64'(14));
        drain();

        // Random packets with random output backpressure.
        rand_rdy = 1'b1;
        for (int p = 0; p < 30; p++) begin
            npkt = $urandom_range(1, 4);
            u = 4'($urandom_range(0, 15));
            for (int w = 0; w < npkt; w++) begin
                send_word(($urandom % 3 == 0) ? 32'($urandom_range(0, 3)) << $urandom_range(0, 31) : $urandom,
                          u, w == npkt - 1);
                repeat ($urandom_range(0, 2)) @(posedge aclk);
                #1;
            end
        end
        drain();
        rand_rdy = 1'b0;
        m_if.tready = 1'b1;
        drain();

        // Reset while in BEAT1, then replay the impulse vector.
        send_word(32'hFFFF_FFFF, 4'hA, 1'b0);
        @(posedge aclk);
        #1;
        m_if.tready = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        check("arst_tvalid", 64'(m_if.tvalid), 64'(0));
        check("arst_tdata", 64'(m_if.tdata), 64'(0));
        check("arst_tuser", 64'(m_if.tuser), 64'(0));
        check("arst_tlast", 64'(m_if.tlast), 64'(0));
        exp_q.delete();
        hist_q.delete();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        m_if.tready = 1'b1;
`ifdef CONV_ENC_STATS_EN
        check("arst_pkt_count", 64'(pkt_count), 64'(0));
`endif
        use_model = 1'b0;
        exp_push(32'h0000_34FB, 4'h1, 1'b0); exp_push(32'h0, 4'h1, 1'b0);
        exp_push(32'h0, 4'h2, 1'b0);         exp_push(32'h0, 4'h2, 1'b1);
        send_word(32'h1, 4'h1, 1'b0);
        send_word(32'h0, 4'h2, 1'b1);
        drain();
`ifdef CONV_ENC_STATS_EN
        check("pkt_count", 64'(pkt_count), 64'(1));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
